// File: rtl/kb_pkg.sv
// Shared constants and types for the PS/2 scan-code to ASCII keyboard FIFO.
// Optional feature macro used by this slice: KB_CAPS_LOCK_EN.
package kb_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam logic [6:0] ASCII_BS    = 7'h08;
  localparam logic [6:0] ASCII_TAB   = 7'h09;
  localparam logic [6:0] ASCII_LF    = 7'h0A;
  localparam logic [6:0] ASCII_ESC   = 7'h1B;
  localparam logic [6:0] ASCII_SPACE = 7'h20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } dec_state_t;

endpackage

// File: rtl/kb_scan2ascii.sv
// Combinational scan-code set 2 make-code to 7-bit ASCII table.
// Caps (driven only when KB_CAPS_LOCK_EN is defined upstream) affects letters only.
module kb_scan2ascii
  import kb_pkg::*;
(
  input  logic       shift,
  input  logic       caps,
  input  logic [7:0] code,
  output logic       valid,
  output logic [6:0] ascii
);

  logic [6:0] base;
  logic [6:0] alt;
  logic       is_letter;

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    valid = 1'b1;
    base  = '0;
    alt   = '0;
    case (code)
      8'h1C: base = 7'h61;  8'h32: base = 7'h62;  8'h21: base = 7'h63;
      8'h23: base = 7'h64;  8'h24: base = 7'h65;  8'h2B: base = 7'h66;
      8'h34: base = 7'h67;  8'h33: base = 7'h68;  8'h43: base = 7'h69;
      8'h3B: base = 7'h6A;  8'h42: base = 7'h6B;  8'h4B: base = 7'h6C;
      8'h3A: base = 7'h6D;  8'h31: base = 7'h6E;  8'h44: base = 7'h6F;
      8'h4D: base = 7'h70;  8'h15: base = 7'h71;  8'h2D: base = 7'h72;
      8'h1B: base = 7'h73;  8'h2C: base = 7'h74;  8'h3C: base = 7'h75;
      8'h2A: base = 7'h76;  8'h1D: base = 7'h77;  8'h22: base = 7'h78;
      8'h35: base = 7'h79;  8'h1A: base = 7'h7A;
      // digits: unshifted digit in base, shifted symbol in alt
      8'h45: begin base = 7'h30; alt = 7'h29; end
      8'h16: begin base = 7'h31; alt = 7'h21; end
      8'h1E: begin base = 7'h32; alt = 7'h40; end
      8'h26: begin base = 7'h33; alt = 7'h23; end
      8'h25: begin base = 7'h34; alt = 7'h24; end
      8'h2E: begin base = 7'h35; alt = 7'h25; end
      8'h36: begin base = 7'h36; alt = 7'h5E; end
      8'h3D: begin base = 7'h37; alt = 7'h26; end
      8'h3E: begin base = 7'h38; alt = 7'h2A; end
      8'h46: begin base = 7'h39; alt = 7'h28; end
      8'h29: begin base = ASCII_SPACE; alt = ASCII_SPACE; end
      8'h5A: begin base = ASCII_LF;    alt = ASCII_LF;    end
      8'h66: begin base = ASCII_BS;    alt = ASCII_BS;    end
      8'h0D: begin base = ASCII_TAB;   alt = ASCII_TAB;   end
      8'h76: begin base = ASCII_ESC;   alt = ASCII_ESC;   end
      default: valid = 1'b0;
    endcase
  end

  // Letters occupy 'a'..'z'; everything else in the table lies below 'a'.
  assign is_letter = (base >= 7'h61) && (base <= 7'h7A);

  always_comb begin
    if (is_letter)
      ascii = (shift ^ caps) ? (base - 7'h20) : base;
    else
      ascii = shift ? alt : base;
  end

endmodule

// File: rtl/kb_ascii_fifo.sv
// Keyboard front end: set-2 prefix decoder, shift/caps tracking and an ASCII FIFO
// with first-word-fall-through head. Caps lock support is enabled by KB_CAPS_LOCK_EN.
module kb_ascii_fifo
  import kb_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  input  logic       KB_read_en,
  input  logic       KB_clear,
  output logic       KB_status,
  output logic [6:0] KB_data,
  output logic       buf_full,
  output logic       overflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  dec_state_t  state;
  logic        shift_l;
  logic        shift_r;
  logic        caps;
  logic        xlat_valid;
  logic [6:0]  xlat_ascii;
  logic        push;
  logic        pop;
  logic        do_push;
  logic [6:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  kb_scan2ascii u_xlat (
    .shift (shift_l | shift_r),
    .caps  (caps),
    .code  (scan_code),
    .valid (xlat_valid),
    .ascii (xlat_ascii)
  );

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      shift_l <= 1'b0;
      shift_r <= 1'b0;
    end else if (scan_valid) begin
      case (state)
        ST_IDLE: begin
          if (scan_code == SC_BREAK)       state <= ST_BRK;
          else if (scan_code == SC_EXT)    state <= ST_EXT;
          else if (scan_code == SC_LSHIFT) shift_l <= 1'b1;
          else if (scan_code == SC_RSHIFT) shift_r <= 1'b1;
        end
        ST_BRK: begin
          state <= ST_IDLE;
          if (scan_code == SC_LSHIFT) shift_l <= 1'b0;
          if (scan_code == SC_RSHIFT) shift_r <= 1'b0;
        end
        ST_EXT:     state <= (scan_code == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

`ifdef KB_CAPS_LOCK_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      caps <= 1'b0;
    else if (scan_valid && state == ST_IDLE && scan_code == SC_CAPS)
      caps <= ~caps;
  end
`else
  assign caps = 1'b0;
`endif

  // Only plain make codes in IDLE that the table maps produce a character.
  assign push = scan_valid && (state == ST_IDLE) &&
                (scan_code != SC_BREAK) && (scan_code != SC_EXT) && xlat_valid;
  assign pop     = KB_read_en && (count != '0);
  assign do_push = push && ((count != FULL_CNT) || pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (KB_clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push && !do_push) overflow <= 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; count gates KB_data so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (do_push && !KB_clear) mem[wr_ptr] <= xlat_ascii;
  end

  assign KB_status = (count != '0);
  assign buf_full  = (count == FULL_CNT);
  assign KB_data   = KB_status ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_kb_ascii_fifo.sv
// Directed bench for kb_ascii_fifo; caps-lock vectors follow KB_CAPS_LOCK_EN.
module tb_kb_ascii_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scan_valid = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       KB_read_en = 1'b0;
  logic       KB_clear = 1'b0;
  logic       KB_status;
  logic [6:0] KB_data;
  logic       buf_full;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  kb_ascii_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_valid (scan_valid),
    .scan_code  (scan_code),
    .KB_read_en (KB_read_en),
    .KB_clear   (KB_clear),
    .KB_status  (KB_status),
    .KB_data    (KB_data),
    .buf_full   (buf_full),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    scan_valid = 1'b1;
    scan_code  = b;
    @(negedge clk);
    scan_valid = 1'b0;
    scan_code  = 8'h00;
  endtask

  task automatic pop_expect(input string tag, input logic [6:0] want);
    @(negedge clk);
    check({tag, "_status"}, 32'(KB_status), 32'd1);
    check(tag, 32'(KB_data), 32'(want));
    KB_read_en = 1'b1;
    @(negedge clk);
    KB_read_en = 1'b0;
  endtask

  task automatic expect_empty(input string tag);
    @(negedge clk);
    check({tag, "_status"}, 32'(KB_status), 32'd0);
    check({tag, "_data"}, 32'(KB_data), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_status", 32'(KB_status), 32'd0);
    check("rst_data", 32'(KB_data), 32'd0);
    check("rst_full", 32'(buf_full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;

    // single char latency and pop back to empty
    @(negedge clk);
    scan_valid = 1'b1;
    scan_code  = 8'h1C;
    check("lat_before", 32'(KB_status), 32'd0);
    @(negedge clk);
    scan_valid = 1'b0;
    check("lat_status", 32'(KB_status), 32'd1);
    check("lat_data", 32'(KB_data), 32'h61);
    pop_expect("t1_a", 7'h61);
    expect_empty("t1_empty");

    // left shift make/break, letter break pushes nothing
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
    send(8'hF0); send(8'h1C);
    pop_expect("t2_A", 7'h41);
    pop_expect("t2_a", 7'h61);
    expect_empty("t2_empty");

    // extended make/break ignored, FSM returns to IDLE
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); send(8'h29);
    pop_expect("t3_space", 7'h20);
    expect_empty("t3_empty");
    send(8'h1C);
    pop_expect("t3_idle", 7'h61);

    // right shift, digits/symbols, control codes, unmapped code
    send(8'h59); send(8'h1C); send(8'h16); send(8'hF0); send(8'h59);
    send(8'h1C); send(8'h45); send(8'h5A); send(8'h66); send(8'h0D);
    send(8'h76); send(8'h07);
    pop_expect("rs_A", 7'h41);
    pop_expect("rs_bang", 7'h21);
    pop_expect("rs_a", 7'h61);
    pop_expect("dig0", 7'h30);
    pop_expect("enter", 7'h0A);
    pop_expect("bksp", 7'h08);
    pop_expect("tab", 7'h09);
    pop_expect("esc", 7'h1B);
    expect_empty("unmapped_empty");

    // reset mid-sequence drops shift and pending break prefix
    send(8'h12); send(8'hF0);
    do_reset();
    send(8'h1C);
    pop_expect("rst_mid", 7'h61);
    expect_empty("rst_mid_empty");

    // push+pop with a single entry: count stays 1, head becomes the new char
    send(8'h1C);
    @(negedge clk);
    KB_read_en = 1'b1; scan_valid = 1'b1; scan_code = 8'h32;
    @(negedge clk);
    KB_read_en = 1'b0; scan_valid = 1'b0;
    pop_expect("pp1_b", 7'h62);
    expect_empty("pp1_empty");

    // fill, simultaneous pop+push at full, overflow drop, drain
    repeat (16) send(8'h1C);
    check("fill_full", 32'(buf_full), 32'd1);
    check("fill_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    KB_read_en = 1'b1; scan_valid = 1'b1; scan_code = 8'h1C;
    @(negedge clk);
    KB_read_en = 1'b0; scan_valid = 1'b0;
    check("ppfull_full", 32'(buf_full), 32'd1);
    check("ppfull_ovf", 32'(overflow), 32'd0);
    send(8'h1C);
    check("drop_full", 32'(buf_full), 32'd1);
    check("drop_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) pop_expect($sformatf("drain%0d", i), 7'h61);
    expect_empty("drain_empty");
    check("drain_full", 32'(buf_full), 32'd0);
    check("drain_ovf_sticky", 32'(overflow), 32'd1);

    // clear beats push in the same cycle
    repeat (5) send(8'h1C);
    @(negedge clk);
    KB_clear = 1'b1; scan_valid = 1'b1; scan_code = 8'h1C;
    @(negedge clk);
    KB_clear = 1'b0; scan_valid = 1'b0;
    check("clr_status", 32'(KB_status), 32'd0);
    check("clr_ovf", 32'(overflow), 32'd0);
    send(8'h1C);
    pop_expect("clr_next", 7'h61);
    expect_empty("clr_empty");

`ifdef KB_CAPS_LOCK_EN
    send(8'h58); send(8'h1C);
    send(8'hF0); send(8'h58); send(8'h1C);
    send(8'h12); send(8'h1C); send(8'h16);
    send(8'hF0); send(8'h12);
    send(8'h58); send(8'h1C);
    pop_expect("caps_A", 7'h41);
    pop_expect("caps_brk", 7'h41);
    pop_expect("caps_shift", 7'h61);
    pop_expect("caps_digit", 7'h21);
    pop_expect("caps_off", 7'h61);
    expect_empty("caps_empty");
`else
    send(8'h58); send(8'h1C);
    pop_expect("nocaps_a", 7'h61);
    expect_empty("nocaps_empty");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
